fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier.
- Successor to the team's single-cycle combinational FP32 multiplier. Adds:
  - configurable exponent and mantissa widths
  - round-to-nearest-even (RNE)
  - special-value handling (zero, inf, NaN)
  - overflow/underflow saturation
  - exception flags
  - valid/ready flow control
- Sits between operand-issue logic and the result writeback in the arithmetic datapath.

Parameters:
- EXP_W, 8, exponent field width (≥3).
- MAN_W, 23, stored fraction width, hidden bit excluded (≥2).
- BIAS is a derived constant, 2^(EXP_W-1)-1. It is not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- b  in  1+EXP_W+MAN_W  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  1+EXP_W+MAN_W  product
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result

Behaviour:
- Reset state: all stage valid bits, out_valid, result and flags are 0. Reset is asynchronous, so an assertion mid-operation discards all in-flight data immediately. in_ready is 1 after reset.
- Flow control uses one global advance signal: adv = !out_valid || out_ready, and in_ready = adv.
  - When adv=0, every stage register holds (full-pipeline stall).
  - Bubbles are not collapsed.
  - A transfer occurs on in_valid && in_ready.
- Latency is exactly 3 cycles with no stalls. Throughput is 1 per cycle.
- A result stays stable while out_valid && !out_ready.
- Stage 1 (unpack/multiply):
  - sign = sa^sb.
  - Classify each operand: zero/denormal (exp=0), inf (exp=all-ones, frac=0), NaN (exp=all-ones, frac≠0).
  - Denormals are treated as zero (DAZ).
  - Product is {1,fa}*{1,fb}, width 2*(MAN_W+1).
  - Exponent sum is ea+eb-BIAS, held signed at EXP_W+2 bits so no wrap-around can occur.
- Stage 2 (normalise/round):
  - If product MSB is 1: shift right by 1 and add 1 to the exponent.
  - Keep MAN_W fraction bits. Guard = next bit, sticky = OR of all remaining bits.
  - Round up when guard && (sticky || lsb).
  - If rounding carries out of the significand, the fraction becomes 0 and the exponent is incremented.
  - inexact_raw = guard || sticky.
- Stage 3 (range/special select, registered output), in priority order:
  1. Either operand NaN, or inf×zero: canonical qNaN {0, all-ones, 1 followed by zeros}. invalid=1, other flags 0.
  2. Either operand inf: {sign, all-ones, 0}. No flags.
  3. Either operand zero/denormal: {sign, 0, 0}. No flags.
  4. Final exponent ≥ 2^EXP_W-1: {sign, all-ones, 0} (inf). overflow=1, inexact=1.
  5. Final exponent ≤ 0: {sign, 0, 0} (flush to zero, FTZ). underflow=1, inexact=1.
  6. Otherwise: the normal packed result, with inexact=inexact_raw.
- Flags are valid only while out_valid=1. They are 0 otherwise.
- Exponent 0 and exponent all-ones with ±inf results are both produced exactly as above. No saturation to max-finite.

Decomposition:
- Shared package fp_pkg holds:
  - the field-width constants and derived BIAS function
  - the operand-class enum (ZERO, NORM, INF, NAN)
  - the flag bit indices (INVALID=3, OVERFLOW=2, UNDERFLOW=1, INEXACT=0)
  - the canonical qNaN constant function
- One natural sub-module, fp_round_rne. It is combinational and takes {normalised significand, exponent}. It returns the rounded fraction, the adjusted exponent and inexact_raw. It is instantiated in stage 2.

Test Plan (defaults, FP32):
1. 0x40400000 × 0x40200000 (3.0×2.5) -> result 0x40F00000 exactly 3 cycles after accept, flags 0.
2. Rounding:
   - 0x3F800001 × 0x3F800001 -> 0x3F800002, inexact=1.
   - Tie case 0x3F800001 × 0x3FC00000 -> 0x3FC00002 (round to even), inexact=1.
3. Specials:
   - 0x00000000 × 0x7F800000 -> 0x7FC00000, invalid=1.
   - 0xFF800000 × 0x40000000 -> 0xFF800000, flags 0.
   - 0x7FC00001 × 0x3F800000 -> 0x7FC00000, invalid=1.
   - denormal 0x00000001 × 0xC0000000 -> 0x80000000, flags 0.
4. Range:
   - 0x7F7FFFFF × 0x40000000 -> 0x7F800000, overflow=1 and inexact=1.
   - 0x00800000 × 0x3F000000 -> 0x00000000, underflow=1 and inexact=1.
5. Backpressure: stream 6 back-to-back operand pairs while holding out_ready=0 for cycles 4-7 -> in_ready=0 during the stall, the held result stays stable, and all 6 results appear in order with none lost or duplicated.
6. Reset: assert rst_n=0 with 3 operations in flight -> out_valid drops immediately and stays 0 after release until new operands are accepted and 3 cycles have elapsed.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath.
// Holds the default field widths, the exponent-bias helper, the operand-class
// enum, the exception-flag bit positions and the canonical quiet-NaN builder.
package fp_pkg;

  // Default IEEE single-precision field widths.
  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  // Widest packed format the helper functions can build.
  localparam int MAX_FP_W = 64;

  // Operand classification used by the special-value selection.
  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } opClass_t;

  // Bit positions inside the 4-bit exception flag vector.
  localparam int INVALID   = 3;
  localparam int OVERFLOW  = 2;
  localparam int UNDERFLOW = 1;
  localparam int INEXACT   = 0;

  // Exponent bias for a given exponent width: 2^(expW-1)-1.
  function automatic int calcBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  // Built right-aligned in a MAX_FP_W vector; callers keep the low bits.
  function automatic logic [MAX_FP_W-1:0] canonicalNan(input int expW, input int manW);
    return (((MAX_FP_W'(1) << expW) - MAX_FP_W'(1)) << manW) | (MAX_FP_W'(1) << (manW - 1));
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even for a normalised product.
// Ports:
//   normFrac   - product bits below the (already dropped) leading one
//   expIn      - signed exponent of the normalised product
//   fracOut    - rounded MAN_W-bit fraction
//   expOut     - exponent, incremented when rounding carries out
//   inexactRaw - any discarded bit was set (guard or sticky)
module fp_round_rne
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic [2*(MAN_W+1)-2:0]   normFrac,
  input  logic signed [EXP_W+1:0]  expIn,
  output logic [MAN_W-1:0]         fracOut,
  output logic signed [EXP_W+1:0]  expOut,
  output logic                     inexactRaw
);

  localparam int FRAC_TOP = 2 * (MAN_W + 1) - 2;

  logic [MAN_W-1:0] fracTrunc;
  logic             guardBit;
  logic             stickyBit;
  logic             roundUp;
  logic [MAN_W:0]   fracSum;

  // Split the fraction into kept bits, the guard bit and the sticky OR of
  // everything below it, then round up on ties only when the kept LSB is odd.
  // A carry out of the fraction leaves the low bits zero and bumps the exponent.
  assign fracTrunc  = normFrac[FRAC_TOP -: MAN_W];
  assign guardBit   = normFrac[FRAC_TOP-MAN_W];
  assign stickyBit  = |normFrac[FRAC_TOP-MAN_W-1:0];
  assign roundUp    = guardBit & (stickyBit | fracTrunc[0]);
  assign fracSum    = {1'b0, fracTrunc} + {{MAN_W{1'b0}}, roundUp};
  assign fracOut    = fracSum[MAN_W-1:0];
  assign expOut     = expIn + (EXP_W+2)'(fracSum[MAN_W]);
  assign inexactRaw = guardBit | stickyBit;

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with RNE rounding,
// special-value handling, FTZ/DAZ and overflow-to-infinity.
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_valid, in_ready  - operand handshake
//   a, b                - operands {sign, exp, frac}
//   out_valid, out_ready- result handshake
//   result, flags       - product and {invalid, overflow, underflow, inexact}
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int EXPS_W = EXP_W + 2;
  localparam int BIAS   = calcBias(EXP_W);

  localparam logic [MAX_FP_W-1:0]      QNAN_FULL = canonicalNan(EXP_W, MAN_W);
  localparam logic [W-1:0]             QNAN      = QNAN_FULL[W-1:0];
  localparam logic [EXP_W-1:0]         EXP_ONES  = '1;
  localparam logic signed [EXPS_W-1:0] EXP_INF   = EXPS_W'((1 << EXP_W) - 1);
  localparam logic signed [EXPS_W-1:0] EXP_ZERO  = '0;
  localparam logic signed [EXPS_W-1:0] BIAS_S    = EXPS_W'(BIAS);

  logic adv;

  logic                     s1Valid, s1Sign;
  opClass_t                 s1ClassA, s1ClassB;
  logic [PROD_W-1:0]        s1Prod;
  logic signed [EXPS_W-1:0] s1Exp;

  logic                     s2Valid, s2Sign;
  opClass_t                 s2ClassA, s2ClassB;
  logic [MAN_W-1:0]         s2Frac;
  logic signed [EXPS_W-1:0] s2Exp;
  logic                     s2Inexact;

  opClass_t                 classA, classB;
  logic [PROD_W-1:0]        prodNext;
  logic signed [EXPS_W-1:0] expSumNext;
  logic [PROD_W-2:0]        normFrac;
  logic signed [EXPS_W-1:0] normExp;
  logic [MAN_W-1:0]         rndFrac;
  logic signed [EXPS_W-1:0] rndExp;
  logic                     rndInexact;
  logic [W-1:0]             resNext;
  logic [3:0]               flagsNext;
  logic                     anyNan, anyInf, anyZero;

  function automatic opClass_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (e == EXP_ONES) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  // A single advance signal stalls the whole pipeline whenever the output
  // register holds a result nobody has taken yet; bubbles are not collapsed.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1 combinational work: classify (denormals fold into ZERO), multiply
  // the significands with hidden ones and form the widened signed exponent.
  assign classA     = classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
  assign classB     = classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
  assign prodNext   = PROD_W'({1'b1, a[MAN_W-1:0]}) * PROD_W'({1'b1, b[MAN_W-1:0]});
  assign expSumNext = $signed({2'b00, a[W-2 -: EXP_W]}) + $signed({2'b00, b[W-2 -: EXP_W]}) - BIAS_S;

  // Stage 1 register: capture the unpacked operands and raw product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid  <= 1'b0;
      s1Sign   <= 1'b0;
      s1ClassA <= ZERO;
      s1ClassB <= ZERO;
      s1Prod   <= '0;
      s1Exp    <= '0;
    end else if (adv) begin
      s1Valid  <= in_valid;
      s1Sign   <= a[W-1] ^ b[W-1];
      s1ClassA <= classA;
      s1ClassB <= classB;
      s1Prod   <= prodNext;
      s1Exp    <= expSumNext;
    end
  end

  // Normalise: the product of two [1,2) significands lies in [1,4); when it
  // reaches 2 the top bit is the leading one, otherwise the next bit is.
  // The leading one itself is dropped before rounding.
  assign normFrac = s1Prod[PROD_W-1] ? s1Prod[PROD_W-2:0] : {s1Prod[PROD_W-3:0], 1'b0};
  assign normExp  = s1Exp + (s1Prod[PROD_W-1] ? EXPS_W'(1) : EXPS_W'(0));

  fp_round_rne #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) uRound (
    .normFrac  (normFrac),
    .expIn     (normExp),
    .fracOut   (rndFrac),
    .expOut    (rndExp),
    .inexactRaw(rndInexact)
  );

  // Stage 2 register: rounded fraction and exponent plus operand classes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid   <= 1'b0;
      s2Sign    <= 1'b0;
      s2ClassA  <= ZERO;
      s2ClassB  <= ZERO;
      s2Frac    <= '0;
      s2Exp     <= '0;
      s2Inexact <= 1'b0;
    end else if (adv) begin
      s2Valid   <= s1Valid;
      s2Sign    <= s1Sign;
      s2ClassA  <= s1ClassA;
      s2ClassB  <= s1ClassB;
      s2Frac    <= rndFrac;
      s2Exp     <= rndExp;
      s2Inexact <= rndInexact;
    end
  end

  assign anyNan  = (s2ClassA == NAN)  || (s2ClassB == NAN);
  assign anyInf  = (s2ClassA == INF)  || (s2ClassB == INF);
  assign anyZero = (s2ClassA == ZERO) || (s2ClassB == ZERO);

  // Stage 3 selection in priority order: invalid operations, infinities,
  // zeros, exponent overflow to infinity, flush-to-zero, then the normal result.
  always_comb begin
    resNext            = {s2Sign, s2Exp[EXP_W-1:0], s2Frac};
    flagsNext          = '0;
    flagsNext[INEXACT] = s2Inexact;
    if (anyNan || (anyInf && anyZero)) begin
      resNext            = QNAN;
      flagsNext          = '0;
      flagsNext[INVALID] = 1'b1;
    end else if (anyInf) begin
      resNext   = {s2Sign, EXP_ONES, {MAN_W{1'b0}}};
      flagsNext = '0;
    end else if (anyZero) begin
      resNext   = {s2Sign, {(W-1){1'b0}}};
      flagsNext = '0;
    end else if (s2Exp >= EXP_INF) begin
      resNext             = {s2Sign, EXP_ONES, {MAN_W{1'b0}}};
      flagsNext           = '0;
      flagsNext[OVERFLOW] = 1'b1;
      flagsNext[INEXACT]  = 1'b1;
    end else if (s2Exp <= EXP_ZERO) begin
      resNext              = {s2Sign, {(W-1){1'b0}}};
      flagsNext            = '0;
      flagsNext[UNDERFLOW] = 1'b1;
      flagsNext[INEXACT]   = 1'b1;
    end
  end

  // Output register: result and flags are forced to zero on bubbles so the
  // flags never show stale values while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= s2Valid;
      result    <= s2Valid ? resNext : '0;
      flags     <= s2Valid ? flagsNext : '0;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed self-checking bench for fp_mult_pipe at FP32 widths.
// Expected results are hand-computed constants held in a small vector table;
// a scoreboard queue keeps them in issue order and a negedge monitor compares.
module tb_fp_mult_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int assertCount = 0;
  int failCount   = 0;

  logic [35:0] expQ[$];
  logic [35:0] monExp;
  logic [35:0] heldOut;
  logic        heldValid;

  logic [31:0] vA[10];
  logic [31:0] vB[10];
  logic [31:0] vRes[10];
  logic [3:0]  vFlg[10];

  fp_mult_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one operand pair (called just after a negedge), wait for the
  // accept edge, queue the expected output and return at the next negedge.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb, input logic [35:0] expOut);
    int k;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    k        = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 64'(in_ready), 64'(1));
    end else begin
      @(posedge clk);
      expQ.push_back(expOut);
      @(negedge clk);
    end
  endtask

  task automatic runVec(input int i);
    applyStimulus(vA[i], vB[i], {vFlg[i], vRes[i]});
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while (expQ.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'(0));
  endtask

  // Monitor: pop and compare on every transfer, check hold stability and
  // in_ready during stalls, and check that flags are zero on bubbles.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      heldValid = 1'b0;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedResult", 64'(out_valid), 64'(0));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("result", 64'(result), 64'(monExp[31:0]));
        checkOutput("flags", 64'(flags), 64'(monExp[35:32]));
      end
    end else if (rst_n && out_valid && !out_ready) begin
      checkOutput("stallInReady", 64'(in_ready), 64'(0));
      if (heldValid) checkOutput("holdStable", 64'({flags, result}), 64'(heldOut));
      heldOut   = {flags, result};
      heldValid = 1'b1;
    end else begin
      heldValid = 1'b0;
      if (rst_n) checkOutput("idleFlags", 64'(flags), 64'(0));
    end
  end

  initial begin
    // Directed vectors with hand-computed products (FP32).
    vA[0] = 32'h40400000; vB[0] = 32'h40200000; vRes[0] = 32'h40F00000; vFlg[0] = 4'b0000;
    vA[1] = 32'h3F800001; vB[1] = 32'h3F800001; vRes[1] = 32'h3F800002; vFlg[1] = 4'b0001;
    vA[2] = 32'h3F800001; vB[2] = 32'h3FC00000; vRes[2] = 32'h3FC00002; vFlg[2] = 4'b0001;
    vA[3] = 32'h00000000; vB[3] = 32'h7F800000; vRes[3] = 32'h7FC00000; vFlg[3] = 4'b1000;
    vA[4] = 32'hFF800000; vB[4] = 32'h40000000; vRes[4] = 32'hFF800000; vFlg[4] = 4'b0000;
    vA[5] = 32'h7FC00001; vB[5] = 32'h3F800000; vRes[5] = 32'h7FC00000; vFlg[5] = 4'b1000;
    vA[6] = 32'h00000001; vB[6] = 32'hC0000000; vRes[6] = 32'h80000000; vFlg[6] = 4'b0000;
    vA[7] = 32'h7F7FFFFF; vB[7] = 32'h40000000; vRes[7] = 32'h7F800000; vFlg[7] = 4'b0101;
    vA[8] = 32'h00800000; vB[8] = 32'h3F000000; vRes[8] = 32'h00000000; vFlg[8] = 4'b0011;
    vA[9] = 32'h3FFFFFFF; vB[9] = 32'h3FFFFFFF; vRes[9] = 32'h407FFFFE; vFlg[9] = 4'b0001;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    heldValid = 1'b0;

    // Reset state.
    #12;
    checkOutput("rstOutValid", 64'(out_valid), 64'(0));
    checkOutput("rstResult", 64'(result), 64'(0));
    checkOutput("rstFlags", 64'(flags), 64'(0));
    checkOutput("rstInReady", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: result visible in the third cycle after the accept edge.
    runVec(0);
    in_valid = 1'b0;
    checkOutput("latencyCyc1", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("latencyCyc2", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("latencyCyc3", 64'(out_valid), 64'(1));
    waitDrain();

    // Rounding, specials and range, issued back to back.
    for (int i = 1; i < 10; i++) runVec(i);
    in_valid = 1'b0;
    waitDrain();

    // Backpressure: six operands streamed while the consumer stalls for four cycles.
    fork
      begin
        for (int i = 0; i < 6; i++) runVec(i);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) runVec(i);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 64'(out_valid), 64'(0));
    checkOutput("midRstResult", 64'(result), 64'(0));
    checkOutput("midRstFlags", 64'(flags), 64'(0));
    expQ.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postRstIdle", 64'(out_valid), 64'(0));
    end
    runVec(7);
    in_valid = 1'b0;
    checkOutput("postRstCyc1", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("postRstCyc2", 64'(out_valid), 64'(0));
    @(negedge clk);
    checkOutput("postRstCyc3", 64'(out_valid), 64'(1));
    waitDrain();

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
